pe_stream_loader: RTL and testbench
===================================

# pe_stream_loader

Upstream/downstream sequencer for the dot-product PE controller. Accepts one frame of 2×VECTOR_SIZE 32-bit words on an AXI-Stream slave, writes them into the shared BRAM through the second BRAM port, and pulses `pe_start`. It then waits for `pe_done`, reads the result from word 0 and emits it as a single-beat AXI-Stream frame. Words 0..V-1 form the global vector; words V..2V-1 form the local vector.

## Interface

Parameters:
- `VECTOR_SIZE`, 16: elements per vector; must equal 2**L_RAM_SIZE.
- `L_RAM_SIZE`, 4: log2 of VECTOR_SIZE.
- `TIMEOUT_CYCLES`, 4096: maximum number of cycles spent in WAIT before the error is flagged.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `s_axis_tdata`  in  32  input words, global vector first.
- `s_axis_tvalid`  in  1.
- `s_axis_tready`  out  1.
- `s_axis_tlast`  in  1  expected on beat 2V-1.
- `m_axis_tdata`  out  32  dot-product result.
- `m_axis_tvalid`  out  1.
- `m_axis_tready`  in  1.
- `m_axis_tlast`  out  1  high whenever m_axis_tvalid is high.
- `pe_start`  out  1  one-cycle start pulse to the controller.
- `pe_done`  in  1  one-cycle completion pulse from the controller.
- `bram_addr`  out  32  byte address (word index << 2).
- `bram_wrdata`  out  32.
- `bram_we`  out  4  byte write enables.
- `bram_en`  out  1.
- `bram_rddata`  in  32  read data, 1-cycle read latency.
- `busy`  out  1  high whenever state ≠ FILL.
- `err_len`  out  1  sticky; cleared by reset only.
- `err_timeout`  out  1  sticky; cleared by reset only.

## Operation

- States: IDLE, FILL, KICK, WAIT, READ, RDWAIT, SEND.
- IDLE: clear the word counter `wcnt` (width L_RAM_SIZE+1) and the timeout counter. Always go to FILL on the next cycle.
- FILL:
  - `s_axis_tready`=1.
  - On each handshake, combinationally drive `bram_en`=1, `bram_we`=4'hF, `bram_addr`=wcnt<<2 and `bram_wrdata`=s_axis_tdata. Then increment `wcnt`.
  - Handshake with wcnt=2V-1: go to KICK. If tlast=0 on that beat, set `err_len`. Frame still proceeds.
  - Handshake with tlast=1 and wcnt<2V-1: set `err_len` and go to IDLE. No `pe_start`; partial data is abandoned.
- KICK: `pe_start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On `pe_done`=1, go to READ.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES, set `err_timeout` and go to IDLE with no output beat.
  - `pe_done` is ignored in every other state.
- READ: `bram_en`=1, `bram_addr`=0, `bram_we`=0. Go to RDWAIT.
- RDWAIT: register `bram_rddata` into the output register. Go to SEND.
- SEND:
  - `m_axis_tvalid`=1 and `m_axis_tlast`=1.
  - `m_axis_tdata` is held stable until `m_axis_tready`=1.
  - On handshake, go to IDLE.
- BRAM outputs are 0 in every state or cycle not listed above.
- Arithmetic:
  - Counters are unsigned with no wrap.
  - The timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Timing

- Reset values:
  - state=IDLE.
  - `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast` and `pe_start` = 0.
  - `m_axis_tdata`=0.
  - `bram_*` outputs = 0.
  - `busy`=1 (state is IDLE).
  - `err_len`=0, `err_timeout`=0.
- After reset deassertion: 1 cycle in IDLE, then `s_axis_tready`=1 on the second cycle.
- Last input beat accepted at cycle T:
  - `pe_start` is high during T+1.
  - WAIT begins at T+2.
- `pe_done` seen at cycle D:
  - READ at D+1.
  - Data captured at the end of D+2.
  - `m_axis_tvalid` is high from D+3.
- Output handshake at cycle S: IDLE at S+1, `s_axis_tready` high again at S+2.
- Reset asserted mid-operation (any state): all registers return to reset values on the next edge. Any pending `pe_start` or output beat is dropped. The controller shares `aresetn`.

## Structure

- Shared package `pe_stream_pkg` holds:
  - the state enum;
  - `RESULT_WORD`=0;
  - the BRAM_WORDS = 2*VECTOR_SIZE helper;
  - the byte-enable constant 4'hF.
- Single module; no sub-module is needed. Counters and output register stay inline.

## Test plan

All scenarios use V=16 and a behavioural 32-word BRAM model with 1-cycle read latency. The controller model pulses `pe_done` 40 cycles after `pe_start` and writes the dot product to word 0.

- Vectors A=1..16 and B=all 2, tlast on beat 31 → exactly one `pe_start` pulse; one output beat with tdata=272 and tlast=1; no error flags.
- tlast on beat 10 → `err_len`=1, no `pe_start`. A following correct frame (A=B=all 1) returns 16.
- No tlast on beat 31 → `err_len`=1, `pe_start` still issued, result still emitted.
- `pe_done` never asserted, TIMEOUT_CYCLES=64 → `err_timeout`=1 after 64 WAIT cycles, no m_axis beat, `s_axis_tready`=1 two cycles later.
- `m_axis_tready` held low for 20 cycles in SEND → tdata stable, `s_axis_tready`=0 throughout, single beat on release.
- Reset asserted during WAIT → next cycle all outputs at reset values. A late `pe_done` is ignored and produces no output beat.

Source files
------------

// File: rtl/pe_stream_pkg.sv
// pe_stream_pkg: definitions shared by the dot-product PE stream loader.
//   state_e      - sequencer states
//   RESULT_WORD  - BRAM word index holding the dot-product result
//   BYTE_EN_ALL  - full-word byte-enable pattern for BRAM writes
//   bram_words() - number of BRAM words occupied by one frame (2 vectors)
`timescale 1ns/1ps
package pe_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_KICK,
    ST_WAIT,
    ST_READ,
    ST_RDWAIT,
    ST_SEND
  } state_e;

  localparam int unsigned RESULT_WORD = 0;
  localparam logic [3:0]  BYTE_EN_ALL = 4'hF;

  // Global vector followed by local vector.
  function automatic int bram_words(input int vector_size);
    return 2 * vector_size;
  endfunction

endpackage

// File: rtl/pe_stream_loader.sv
// pe_stream_loader: streams one frame (global vector then local vector) from
// an AXI-Stream slave into the shared BRAM, kicks the dot-product controller,
// waits for completion, reads the result from word 0 and emits it as a
// single-beat AXI-Stream frame.
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   s_axis_*              input words (tdata/tvalid/tready/tlast)
//   m_axis_*              result beat (tdata/tvalid/tready/tlast)
//   pe_start / pe_done    one-cycle handshake pulses with the PE controller
//   bram_*                BRAM port B (byte address, 1-cycle read latency)
//   busy                  high whenever the loader is not accepting input
//   err_len, err_timeout  sticky error flags, cleared only by reset
`timescale 1ns/1ps
module pe_stream_loader
  import pe_stream_pkg::*;
#(
  parameter int VECTOR_SIZE    = 16,
  parameter int L_RAM_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        pe_start,
  input  logic        pe_done,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wrdata,
  output logic [3:0]  bram_we,
  output logic        bram_en,
  input  logic [31:0] bram_rddata,
  output logic        busy,
  output logic        err_len,
  output logic        err_timeout
);

  localparam int WCNT_W = L_RAM_SIZE + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(bram_words(VECTOR_SIZE) - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);

  state_e             state_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic [TCNT_W-1:0]  tcnt_q;
  logic [TCNT_W-1:0]  tcnt_d;
  logic [31:0]        result_q;
  logic               err_len_q;
  logic               err_timeout_q;
  logic               fill_hs;

  assign fill_hs = (state_q == ST_FILL) && s_axis_tvalid;
  assign tcnt_d  = tcnt_q + TCNT_W'(1);

  // Outputs are pure decodes of registered state.
  assign s_axis_tready = (state_q == ST_FILL);
  assign pe_start      = (state_q == ST_KICK);
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tlast  = (state_q == ST_SEND);
  assign m_axis_tdata  = result_q;
  assign busy          = (state_q != ST_FILL);
  assign err_len       = err_len_q;
  assign err_timeout   = err_timeout_q;

  // BRAM port: write-through of accepted beats in FILL, a single result read
  // in READ, idle (all zero) otherwise.
  always_comb begin
    bram_en     = 1'b0;
    bram_we     = 4'h0;
    bram_addr   = 32'h0;
    bram_wrdata = 32'h0;
    if (fill_hs) begin
      bram_en     = 1'b1;
      bram_we     = BYTE_EN_ALL;
      bram_addr   = 32'(wcnt_q) << 2;
      bram_wrdata = s_axis_tdata;
    end else if (state_q == ST_READ) begin
      bram_en   = 1'b1;
      bram_addr = 32'(RESULT_WORD) << 2;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      wcnt_q        <= '0;
      tcnt_q        <= '0;
      result_q      <= 32'h0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wcnt_q  <= '0;
          tcnt_q  <= '0;
          state_q <= ST_FILL;
        end
        ST_FILL: begin
          if (s_axis_tvalid) begin
            if (wcnt_q == LAST_WORD) begin
              // Full frame: run it even if tlast is missing, but flag it.
              if (!s_axis_tlast) err_len_q <= 1'b1;
              state_q <= ST_KICK;
            end else if (s_axis_tlast) begin
              // Short frame: abandon the partial data, never start the PE.
              err_len_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              wcnt_q <= wcnt_q + WCNT_W'(1);
            end
          end
        end
        ST_KICK: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (pe_done) begin
            state_q <= ST_READ;
          end else if (tcnt_d == TCNT_MAX) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end
        ST_READ:   state_q <= ST_RDWAIT;
        ST_RDWAIT: begin
          // Read issued in READ arrives one cycle later.
          result_q <= bram_rddata;
          state_q  <= ST_SEND;
        end
        ST_SEND: begin
          if (m_axis_tready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_loader.sv
`timescale 1ns/1ps
module tb_pe_stream_loader;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        pe_start;
  logic        pe_done;
  logic [31:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;
  logic        bram_en;
  logic [31:0] bram_rddata;
  logic        busy;
  logic        err_len;
  logic        err_timeout;

  always #5 aclk = ~aclk;

  pe_stream_loader #(
    .VECTOR_SIZE(16),
    .L_RAM_SIZE(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .pe_start(pe_start),
    .pe_done(pe_done),
    .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata),
    .bram_we(bram_we),
    .bram_en(bram_en),
    .bram_rddata(bram_rddata),
    .busy(busy),
    .err_len(err_len),
    .err_timeout(err_timeout)
  );

  // Behavioural 32-word BRAM plus PE controller model.
  logic [31:0] mem [32];
  logic [31:0] rd_q = 32'h0;
  logic        pe_done_auto = 1'b0;
  logic        pe_done_man = 1'b0;
  bit          ctrl_auto = 1'b1;
  logic        ctrl_busy = 1'b0;
  int          ctrl_cnt = 0;

  assign bram_rddata = rd_q;
  assign pe_done     = pe_done_auto | pe_done_man;

  function automatic logic [31:0] dot_mem();
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < 16; i++) s = s + mem[i] * mem[i+16];
    return s;
  endfunction

  always @(posedge aclk) begin
    pe_done_auto <= 1'b0;
    if (bram_en) begin
      if (bram_we == 4'hF) mem[bram_addr[6:2]] <= bram_wrdata;
      rd_q <= mem[bram_addr[6:2]];
    end
    if (!aresetn) begin
      ctrl_busy <= 1'b0;
      ctrl_cnt  <= 0;
    end else if (pe_start && ctrl_auto) begin
      ctrl_busy <= 1'b1;
      ctrl_cnt  <= 1;
    end else if (ctrl_busy) begin
      if (ctrl_cnt == 39) begin
        mem[0]       <= dot_mem();
        pe_done_auto <= 1'b1;
        ctrl_busy    <= 1'b0;
      end
      ctrl_cnt <= ctrl_cnt + 1;
    end
  end

  // Monitors.
  int          cyc = 0;
  int          start_cnt = 0;
  int          beat_cnt = 0;
  int          done_cyc = 0;
  int          vld_cyc = 0;
  logic        vld_prev = 1'b0;
  logic [31:0] beat_data = 32'h0;
  logic        beat_last = 1'b0;

  always @(posedge aclk) begin
    cyc      <= cyc + 1;
    vld_prev <= m_axis_tvalid;
    if (aresetn) begin
      if (pe_start) start_cnt <= start_cnt + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt  <= beat_cnt + 1;
        beat_data <= m_axis_tdata;
        beat_last <= m_axis_tlast;
      end
      if (pe_done) done_cyc <= cyc;
      if (m_axis_tvalid && !vld_prev) vld_cyc <= cyc;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] frame [32];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pe_done_man   = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // kind 0: A=1..16, B=2   kind 1: A=B=1   kind 2: A=1..16, B=1
  task automatic set_frame(input int kind);
    for (int i = 0; i < 16; i++) begin
      frame[i]    = (kind == 1) ? 32'd1 : 32'(i + 1);
      frame[i+16] = (kind == 0) ? 32'd2 : 32'd1;
    end
  endtask

  // Sends n beats; tlast asserted on beat last_beat. Returns at #1 after the
  // edge that accepted the final beat.
  task automatic send_frame(input int n, input int last_beat);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = frame[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == last_beat);
      ok = 1'b0;
      for (int g = 0; g < 200 && !ok; g++) begin
        @(negedge aclk);
        if (s_axis_tready) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL send_beat beat %0d got tready=0 want tready=1", i);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_beat(input int prev, output bit ok);
    for (int g = 0; g < 300 && beat_cnt == prev; g++) tick();
    ok = (beat_cnt != prev);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, pe_start, busy, err_len, err_timeout} !== 7'b0000100) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000100",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, pe_start, busy, err_len, err_timeout});
    end
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_wrdata, m_axis_tdata} !== 101'h0) begin
      errors++;
      $display("FAIL reset_data got en=%b we=%h addr=%h wd=%h tdata=%h want all 0",
               bram_en, bram_we, bram_addr, bram_wrdata, m_axis_tdata);
    end
    aresetn = 1'b1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_cycle got tready=%b want 0", s_axis_tready);
    end
    tick();
    checks++;
    if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill got tready=%b busy=%b want 1 0", s_axis_tready, busy);
    end
  endtask

  task automatic test_basic();
    int s0, b0;
    bit ok;
    s0 = start_cnt;
    b0 = beat_cnt;
    set_frame(0);
    send_frame(32, 31);
    checks++;
    if (pe_start !== 1'b1) begin
      errors++;
      $display("FAIL basic_kick got pe_start=%b want 1", pe_start);
    end
    tick();
    checks++;
    if (pe_start !== 1'b0) begin
      errors++;
      $display("FAIL basic_kick_pulse got pe_start=%b want 0", pe_start);
    end
    checks++;
    if (mem[15] !== 32'd16 || mem[16] !== 32'd2 || mem[31] !== 32'd2) begin
      errors++;
      $display("FAIL basic_bram got %0d %0d %0d want 16 2 2", mem[15], mem[16], mem[31]);
    end
    wait_beat(b0, ok);
    checks++;
    if (!ok || beat_data !== 32'd272 || beat_last !== 1'b1) begin
      errors++;
      $display("FAIL basic_result got beat=%b data=%0d last=%b want 1 272 1", ok, beat_data, beat_last);
    end
    checks++;
    if (start_cnt - s0 != 1 || beat_cnt - b0 != 1) begin
      errors++;
      $display("FAIL basic_counts got starts=%0d beats=%0d want 1 1", start_cnt - s0, beat_cnt - b0);
    end
    checks++;
    if (vld_cyc - done_cyc != 3) begin
      errors++;
      $display("FAIL basic_latency got %0d want 3", vld_cyc - done_cyc);
    end
    checks++;
    if ({err_len, err_timeout, s_axis_tready, m_axis_tvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_after_send got %b want 0000", {err_len, err_timeout, s_axis_tready, m_axis_tvalid});
    end
    tick();
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL basic_rearm got tready=%b want 1", s_axis_tready);
    end
  endtask

  task automatic test_short_frame();
    int s0, b0;
    bit ok;
    do_reset();
    s0 = start_cnt;
    b0 = beat_cnt;
    set_frame(1);
    send_frame(11, 10);
    checks++;
    if (err_len !== 1'b1 || pe_start !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL short_abort got err_len=%b pe_start=%b tready=%b want 1 0 0", err_len, pe_start, s_axis_tready);
    end
    tick();
    send_frame(32, 31);
    wait_beat(b0, ok);
    checks++;
    if (!ok || beat_data !== 32'd16 || start_cnt - s0 != 1 || err_len !== 1'b1) begin
      errors++;
      $display("FAIL short_recover got beat=%b data=%0d starts=%0d err_len=%b want 1 16 1 1",
               ok, beat_data, start_cnt - s0, err_len);
    end
  endtask

  task automatic test_no_tlast();
    int b0;
    bit ok;
    do_reset();
    b0 = beat_cnt;
    set_frame(2);
    send_frame(32, -1);
    checks++;
    if (err_len !== 1'b1 || pe_start !== 1'b1) begin
      errors++;
      $display("FAIL notlast_flag got err_len=%b pe_start=%b want 1 1", err_len, pe_start);
    end
    wait_beat(b0, ok);
    checks++;
    if (!ok || beat_data !== 32'd136) begin
      errors++;
      $display("FAIL notlast_result got beat=%b data=%0d want 1 136", ok, beat_data);
    end
  endtask

  task automatic test_timeout();
    int b0;
    do_reset();
    ctrl_auto = 1'b0;
    b0 = beat_cnt;
    set_frame(1);
    send_frame(32, 31);
    repeat (64) tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early got err_timeout=%b busy=%b want 0 1", err_timeout, busy);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag got err_timeout=%b tready=%b want 1 0", err_timeout, s_axis_tready);
    end
    tick();
    checks++;
    if (s_axis_tready !== 1'b1 || beat_cnt != b0) begin
      errors++;
      $display("FAIL timeout_rearm got tready=%b beats=%0d want 1 0", s_axis_tready, beat_cnt - b0);
    end
    ctrl_auto = 1'b1;
  endtask

  task automatic test_backpressure();
    int b0;
    do_reset();
    m_axis_tready = 1'b0;
    b0 = beat_cnt;
    set_frame(1);
    send_frame(32, 31);
    for (int g = 0; g < 200 && !m_axis_tvalid; g++) tick();
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid got tvalid=%b want 1", m_axis_tvalid);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata} !== {3'b110, 32'd16}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got tvalid=%b tlast=%b tready=%b tdata=%0d want 1 1 0 16",
                 i, m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata);
      end
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    checks++;
    if (beat_cnt - b0 != 1 || beat_data !== 32'd16 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got beats=%0d data=%0d tvalid=%b tready=%b want 1 16 0 0",
               beat_cnt - b0, beat_data, m_axis_tvalid, s_axis_tready);
    end
    tick();
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rearm got tready=%b want 1", s_axis_tready);
    end
  endtask

  task automatic test_reset_in_wait();
    int b0;
    bit ok;
    do_reset();
    ctrl_auto = 1'b0;
    b0 = beat_cnt;
    set_frame(1);
    send_frame(32, 31);
    repeat (5) tick();
    aresetn = 1'b0;
    tick();
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, pe_start, bram_en, bram_we, busy, err_len, err_timeout} !== 12'b000000000100
        || m_axis_tdata !== 32'h0) begin
      errors++;
      $display("FAIL rstwait_outputs got tready=%b tvalid=%b pe_start=%b en=%b busy=%b tdata=%0d want 0 0 0 0 1 0",
               s_axis_tready, m_axis_tvalid, pe_start, bram_en, busy, m_axis_tdata);
    end
    aresetn     = 1'b1;
    pe_done_man = 1'b1;
    tick();
    pe_done_man = 1'b0;
    tick();
    pe_done_man = 1'b1;
    tick();
    pe_done_man = 1'b0;
    repeat (10) tick();
    checks++;
    if (beat_cnt != b0 || s_axis_tready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_late_done got beats=%0d tready=%b busy=%b want 0 1 0",
               beat_cnt - b0, s_axis_tready, busy);
    end
    ctrl_auto = 1'b1;
    send_frame(32, 31);
    wait_beat(b0, ok);
    checks++;
    if (!ok || beat_data !== 32'd16) begin
      errors++;
      $display("FAIL rstwait_recover got beat=%b data=%0d want 1 16", ok, beat_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_short_frame();
    test_no_tlast();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
